// File: rtl/sprite_motion.sv
// Per-frame sprite position controller: keycode sets velocity, position steps once per frame with edge bounce.
// Position/moving update 4 Clk edges after frame_clk is first sampled high; ticks arriving mid-update are dropped.
module sprite_motion #(
  parameter int X_INIT = 320,
  parameter int Y_INIT = 240,
  parameter int X_MIN  = 0,
  parameter int X_MAX  = 639,
  parameter int Y_MIN  = 0,
  parameter int Y_MAX  = 479,
  parameter int SIZE_X = 16,
  parameter int SIZE_Y = 16,
  parameter int STEP   = 2
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       frame_clk,
  input  logic [7:0] keycode,
  output logic [9:0] X_pos,
  output logic [9:0] Y_pos,
  output logic [9:0] Size_X,
  output logic [9:0] Size_Y,
  output logic       moving
);

  typedef enum logic [1:0] {IDLE, CALC, COMMIT} state_t;

  localparam logic signed [10:0] X_HI   = 11'(X_MAX - SIZE_X + 1);
  localparam logic signed [10:0] X_LO   = 11'(X_MIN);
  localparam logic signed [10:0] Y_HI   = 11'(Y_MAX - SIZE_Y + 1);
  localparam logic signed [10:0] Y_LO   = 11'(Y_MIN);
  localparam logic signed [10:0] STEP_S = 11'(STEP);

  state_t             state, state_nxt;
  logic signed [10:0] vel_x, vel_y, vel_x_nxt, vel_y_nxt;
  logic signed [10:0] nx, ny;
  logic [9:0]         x_nxt, y_nxt;
  logic               moving_nxt;
  logic               s1, s2, s3, tick;

  assign Size_X = 10'(SIZE_X);
  assign Size_Y = 10'(SIZE_Y);

  // frame_clk is asynchronous: two-flop synchronizer, then edge detect
  always_ff @(posedge Clk) begin
    if (Reset) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= frame_clk;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign tick = s2 & ~s3;

  always_comb begin
    state_nxt  = state;
    vel_x_nxt  = vel_x;
    vel_y_nxt  = vel_y;
    x_nxt      = X_pos;
    y_nxt      = Y_pos;
    moving_nxt = moving;
    nx         = signed'({1'b0, X_pos}) + vel_x;
    ny         = signed'({1'b0, Y_pos}) + vel_y;

    unique case (state)
      IDLE: begin
        if (tick) state_nxt = CALC;
      end
      CALC: begin
        case (keycode)
          8'h04: begin vel_x_nxt = -STEP_S; vel_y_nxt = '0;      end
          8'h07: begin vel_x_nxt =  STEP_S; vel_y_nxt = '0;      end
          8'h1A: begin vel_x_nxt = '0;      vel_y_nxt = -STEP_S; end
          8'h16: begin vel_x_nxt = '0;      vel_y_nxt =  STEP_S; end
          default: ;
        endcase
        state_nxt = COMMIT;
      end
      COMMIT: begin
        // Clamp to the edge and reflect; STEP < SIZE keeps the bounce one step deep
        if (nx > X_HI) begin
          x_nxt     = X_HI[9:0];
          vel_x_nxt = -vel_x;
        end else if (nx < X_LO) begin
          x_nxt     = X_LO[9:0];
          vel_x_nxt = -vel_x;
        end else begin
          x_nxt = nx[9:0];
        end

        if (ny > Y_HI) begin
          y_nxt     = Y_HI[9:0];
          vel_y_nxt = -vel_y;
        end else if (ny < Y_LO) begin
          y_nxt     = Y_LO[9:0];
          vel_y_nxt = -vel_y;
        end else begin
          y_nxt = ny[9:0];
        end

        moving_nxt = (vel_x_nxt != '0) || (vel_y_nxt != '0);
        state_nxt  = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state  <= IDLE;
      vel_x  <= '0;
      vel_y  <= '0;
      X_pos  <= 10'(X_INIT);
      Y_pos  <= 10'(Y_INIT);
      moving <= 1'b0;
    end else begin
      state  <= state_nxt;
      vel_x  <= vel_x_nxt;
      vel_y  <= vel_y_nxt;
      X_pos  <= x_nxt;
      Y_pos  <= y_nxt;
      moving <= moving_nxt;
    end
  end

endmodule
